data_pl_ps_axil_fifo_slave: RTL and testbench

AXI4-Lite slave that sits directly downstream of the PS master VIP/GP port and exposes a PL-side sample FIFO to software. PL logic pushes 32-bit words with a valid/ready handshake. The PS reads them one at a time through a DATA register, and polls status or takes an interrupt. Four 32-bit registers at word offsets 0x0–0xC.

---
 rtl/data_pl_ps_axil_fifo_slave_if.sv | 35 +++
 rtl/data_pl_ps_axil_fifo_slave.sv | 112 +++++++++++
 tb/tb_data_pl_ps_axil_fifo_slave.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_pl_ps_axil_fifo_slave_if.sv
// data_pl_ps_axil_fifo_slave_if: AXI4-Lite bus bundle between the PS master and the FIFO slave
// Signals: aw*/w*/b* write address, data and response channels; ar*/r* read address and data channels.
// Modports: master drives addresses, data and response-ready; slave drives readies, responses and read data.
interface data_pl_ps_axil_fifo_slave_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/data_pl_ps_axil_fifo_slave.sv
// data_pl_ps_axil_fifo_slave: AXI4-Lite slave exposing a PL-side sample FIFO to PS software
// Ports: S_AXI_ACLK clock; S_AXI_ARESETN async active-low reset; s_axi AXI4-Lite slave bus
//        (CTRL 0x0, THRESH 0x4, DATA 0x8 pops, STATUS 0xC); pl_data/pl_valid/pl_ready PL push
//        handshake; irq registered level interrupt on FIFO count reaching THRESH.
module data_pl_ps_axil_fifo_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH         = 16
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESETN,
   data_pl_ps_axil_fifo_slave_if.slave s_axi,
   input  logic [31:0]                 pl_data,
   input  logic                        pl_valid,
   output logic                        pl_ready,
   output logic                        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
   logic [7:0] thresh_q, thresh_d;
   logic awready_q, awready_d, bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
   logic en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, unf_q, unf_d, irq_q, irq_d;
   logic wr, rd, empty, full, push, pop, flush, data_rd, st_wr;
   logic [1:0] wa, ra;
   logic [31:0] status;
   logic unused;
   assign awaddr = s_axi.awaddr;
   assign araddr = s_axi.araddr;
   assign wa = awaddr[3:2];
   assign ra = araddr[3:2];
   assign unused = ^{s_axi.awprot, s_axi.arprot, s_axi.wdata, s_axi.wstrb, awaddr[1:0], araddr[1:0]};
   // the registered ready pulse marks the handshake cycle, valids are still held by the master
   assign wr = awready_q;
   assign rd = arready_q;
   assign empty = cnt_q == '0;
   assign full = cnt_q == CW'(FIFO_DEPTH);
   assign pl_ready = en_q & ~full;
   assign push = pl_valid & pl_ready;
   assign data_rd = rd & (ra == 2'd2);
   assign pop = data_rd & ~empty;
   assign flush = wr & (wa == 2'd0) & s_axi.wstrb[0] & s_axi.wdata[1];
   assign st_wr = wr & (wa == 2'd3) & s_axi.wstrb[2];
   assign status = {12'd0, unf_q, ovf_q, full, empty, 7'd0, 9'(cnt_q)};
   assign s_axi.awready = awready_q;
   assign s_axi.wready = awready_q;
   assign s_axi.bresp = 2'b00;
   assign s_axi.bvalid = bvalid_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rdata = rdata_q;
   assign s_axi.rresp = 2'b00;
   assign s_axi.rvalid = rvalid_q;
   assign irq = irq_q;
   always_comb begin
      awready_d = s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
      bvalid_d = wr | (bvalid_q & ~s_axi.bready);
      arready_d = s_axi.arvalid & ~rvalid_q & ~arready_q;
      rvalid_d = rd | (rvalid_q & ~s_axi.rready);
      rdata_d = !rd ? rdata_q :
                ra == 2'd0 ? {29'd0, irq_en_q, 1'b0, en_q} :
                ra == 2'd1 ? {24'd0, thresh_q} :
                ra == 2'd2 ? (empty ? 32'd0 : mem[rptr_q]) : status;
      en_d = wr & (wa == 2'd0) & s_axi.wstrb[0] ? s_axi.wdata[0] : en_q;
      irq_en_d = wr & (wa == 2'd0) & s_axi.wstrb[0] ? s_axi.wdata[2] : irq_en_q;
      thresh_d = wr & (wa == 2'd1) & s_axi.wstrb[0] ? s_axi.wdata[7:0] : thresh_q;
      // a new event in the same cycle as its W1C clear wins, so no event is lost
      ovf_d = (ovf_q & ~(st_wr & s_axi.wdata[18])) | (en_q & pl_valid & full);
      unf_d = (unf_q & ~(st_wr & s_axi.wdata[19])) | (data_rd & empty);
      cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
      wptr_d = flush ? '0 : wptr_q + AW'(push);
      rptr_d = flush ? '0 : rptr_q + AW'(pop);
      irq_d = irq_en_d & (|thresh_d) & (9'(cnt_d) >= {1'b0, thresh_d});
   end
   always_ff @(posedge S_AXI_ACLK)
      if (push) mem[wptr_q] <= pl_data;
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
      if (!S_AXI_ARESETN) begin
         awready_q <= 1'b0;
         bvalid_q <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q <= '0;
         en_q <= 1'b0;
         irq_en_q <= 1'b0;
         thresh_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         cnt_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         irq_q <= 1'b0;
      end else begin
         awready_q <= awready_d;
         bvalid_q <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q <= rvalid_d;
         rdata_q <= rdata_d;
         en_q <= en_d;
         irq_en_q <= irq_en_d;
         thresh_q <= thresh_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         cnt_q <= cnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         irq_q <= irq_d;
      end
endmodule

// File: tb/tb_data_pl_ps_axil_fifo_slave.sv
// tb_data_pl_ps_axil_fifo_slave: randomized self-checking bench against a queue-based model
module tb_data_pl_ps_axil_fifo_slave;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] pl_data = '0;
   logic pl_valid = 1'b0;
   logic pl_ready, irq;
   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] q[$];
   logic m_irq_en = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
   logic [7:0] m_thresh = '0;
   data_pl_ps_axil_fifo_slave_if #(.ADDR_W(4), .DATA_W(32)) s ();
   data_pl_ps_axil_fifo_slave #(.FIFO_DEPTH(DEPTH)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(s),
      .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .irq(irq)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] m_status();
      return {12'd0, m_unf, m_ovf, q.size() == DEPTH, q.size() == 0, 7'd0, 9'(q.size())};
   endfunction
   function automatic logic m_irq();
      return m_irq_en && m_thresh != 0 && q.size() >= int'(m_thresh);
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] strb);
      int n = 0;
      s.awaddr = a; s.wdata = d; s.wstrb = strb; s.awvalid = 1'b1; s.wvalid = 1'b1;
      while (!s.awready && n < 20) begin tick(); n++; end
      n_checks++;
      if (!(s.awready && s.wready)) begin n_fail++; $display("FAIL aw_w_ready: awready=%b wready=%b required 1 1", s.awready, s.wready); end
      tick();
      s.awvalid = 1'b0; s.wvalid = 1'b0; s.bready = 1'b1;
      n = 0;
      while (!s.bvalid && n < 20) begin tick(); n++; end
      n_checks++;
      if (s.bvalid !== 1'b1 || s.bresp !== 2'b00) begin n_fail++; $display("FAIL bresp: bvalid=%b bresp=%b required 1 00", s.bvalid, s.bresp); end
      tick();
      s.bready = 1'b0;
   endtask
   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int n = 0;
      logic [31:0] first;
      s.araddr = a; s.arvalid = 1'b1;
      while (!s.arready && n < 20) begin tick(); n++; end
      n_checks++;
      if (s.arready !== 1'b1) begin n_fail++; $display("FAIL ar_timeout: arready=%b required 1", s.arready); end
      tick();
      s.arvalid = 1'b0;
      n = 0;
      while (!s.rvalid && n < 20) begin tick(); n++; end
      first = s.rdata;
      if ($urandom_range(0, 1) == 1) begin
         tick();
         n_checks++;
         if (s.rvalid !== 1'b1 || s.rdata !== first) begin n_fail++; $display("FAIL r_hold: rvalid=%b rdata=%h required 1 %h", s.rvalid, s.rdata, first); end
      end
      n_checks++;
      if (s.rvalid !== 1'b1 || s.rresp !== 2'b00) begin n_fail++; $display("FAIL rresp: rvalid=%b rresp=%b required 1 00", s.rvalid, s.rresp); end
      d = s.rdata;
      s.rready = 1'b1;
      tick();
      s.rready = 1'b0;
   endtask
   task automatic push_word(input logic [31:0] d);
      int n = 0;
      pl_data = d; pl_valid = 1'b1;
      while (!pl_ready && n < 20) begin tick(); n++; end
      n_checks++;
      if (pl_ready !== 1'b1) begin n_fail++; $display("FAIL push_timeout: pl_ready=%b required 1", pl_ready); end
      tick();
      pl_valid = 1'b0;
      q.push_back(d);
   endtask
   task automatic test_reset();
      logic [31:0] r;
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({s.awready, s.wready, s.bvalid, s.arready, s.rvalid, pl_ready, irq, s.bresp, s.rresp} !== 11'd0 || s.rdata !== 32'd0) begin
         n_fail++; $display("FAIL reset_outputs: hs=%b rdata=%h required 0 0", {s.awready, s.wready, s.bvalid, s.arready, s.rvalid, pl_ready, irq}, s.rdata);
      end
      rst_n = 1'b1;
      tick();
      axi_read(4'h0, r);
      n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", r); end
      axi_read(4'h4, r);
      n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_thresh: got %h required 0", r); end
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0001_0000) begin n_fail++; $display("FAIL reset_status: got %h required 00010000", r); end
      n_checks++; if (pl_ready !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_pl_irq: pl_ready=%b irq=%b required 0 0", pl_ready, irq); end
   endtask
   task automatic test_regs();
      logic [31:0] r;
      axi_write(4'h0, 32'h1, 4'hF);
      axi_write(4'h4, 32'h3, 4'hF);
      axi_read(4'h0, r);
      n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL ctrl_rb: got %h required 1", r); end
      axi_read(4'h4, r);
      n_checks++; if (r !== 32'h3) begin n_fail++; $display("FAIL thresh_rb: got %h required 3", r); end
      axi_write(4'h4, 32'hFFFF_FFFF, 4'b0001);
      axi_read(4'h4, r);
      n_checks++; if (r !== 32'hFF) begin n_fail++; $display("FAIL thresh_strb: got %h required ff", r); end
      axi_write(4'h4, 32'h0, 4'b1110);
      axi_read(4'h4, r);
      n_checks++; if (r !== 32'hFF) begin n_fail++; $display("FAIL thresh_nostrb: got %h required ff", r); end
      axi_write(4'h8, 32'h1234_5678, 4'hF);
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0001_0000) begin n_fail++; $display("FAIL data_write_ignored: got %h required 00010000", r); end
      axi_write(4'h4, 32'h0, 4'hF);
      m_thresh = 8'h0;
   endtask
   task automatic test_fifo_basic();
      logic [31:0] r, e;
      for (int i = 1; i <= 4; i++) push_word(32'(i));
      axi_read(4'hC, r);
      n_checks++; if (r !== m_status()) begin n_fail++; $display("FAIL count4: got %h required %h", r, m_status()); end
      for (int i = 0; i < 4; i++) begin
         e = q.pop_front();
         axi_read(4'h8, r);
         n_checks++; if (r !== e) begin n_fail++; $display("FAIL pop_order: got %h required %h", r, e); end
      end
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0001_0000) begin n_fail++; $display("FAIL drained: got %h required 00010000", r); end
      axi_read(4'h8, r);
      m_unf = 1'b1;
      n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL underflow_data: got %h required 0", r); end
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0009_0000) begin n_fail++; $display("FAIL unf_set: got %h required 00090000", r); end
      axi_write(4'hC, 32'h0008_0000, 4'hF);
      m_unf = 1'b0;
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0001_0000) begin n_fail++; $display("FAIL unf_clear: got %h required 00010000", r); end
   endtask
   task automatic test_full();
      logic [31:0] r, e, w17;
      pl_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         pl_data = $urandom;
         q.push_back(pl_data);
         n_checks++; if (pl_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: word %0d pl_ready=%b required 1", i, pl_ready); end
         tick();
      end
      w17 = $urandom;
      pl_data = w17;
      n_checks++; if (pl_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: pl_ready=%b required 0", pl_ready); end
      tick();
      m_ovf = 1'b1;
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0006_0010) begin n_fail++; $display("FAIL full_status: got %h required 00060010", r); end
      e = q.pop_front();
      axi_read(4'h8, r);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL full_pop: got %h required %h", r, e); end
      q.push_back(w17);
      n_checks++; if (pl_ready !== 1'b0) begin n_fail++; $display("FAIL refull_ready: pl_ready=%b required 0", pl_ready); end
      pl_valid = 1'b0;
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0006_0010) begin n_fail++; $display("FAIL refull_status: got %h required 00060010", r); end
      axi_write(4'hC, 32'h0004_0000, 4'hF);
      m_ovf = 1'b0;
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0002_0010) begin n_fail++; $display("FAIL ovf_clear: got %h required 00020010", r); end
      while (q.size() > 0) begin
         e = q.pop_front();
         axi_read(4'h8, r);
         n_checks++; if (r !== e) begin n_fail++; $display("FAIL full_drain: got %h required %h", r, e); end
      end
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0001_0000) begin n_fail++; $display("FAIL full_empty: got %h required 00010000", r); end
   endtask
   task automatic test_irq();
      logic [31:0] r, e;
      int n = 0;
      axi_write(4'h0, 32'h5, 4'hF);
      axi_write(4'h4, 32'h2, 4'hF);
      m_irq_en = 1'b1; m_thresh = 8'd2;
      push_word($urandom);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_below: irq=%b required 0", irq); end
      push_word($urandom);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: irq=%b required 1", irq); end
      s.araddr = 4'h8; s.arvalid = 1'b1;
      while (!s.arready && n < 20) begin tick(); n++; end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: irq=%b required 1", irq); end
      tick();
      s.arvalid = 1'b0;
      e = q.pop_front();
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: irq=%b required 0", irq); end
      n_checks++; if (s.rvalid !== 1'b1 || s.rdata !== e) begin n_fail++; $display("FAIL irq_pop: rvalid=%b rdata=%h required 1 %h", s.rvalid, s.rdata, e); end
      s.rready = 1'b1; tick(); s.rready = 1'b0;
      axi_write(4'h4, 32'h0, 4'hF);
      m_thresh = 8'd0;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_thresh0: irq=%b required 0", irq); end
      axi_write(4'h4, 32'h1, 4'hF);
      m_thresh = 8'd1;
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_thresh1: irq=%b required 1", irq); end
      axi_write(4'h0, 32'h1, 4'hF);
      m_irq_en = 1'b0;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disable: irq=%b required 0", irq); end
      e = q.pop_front();
      axi_read(4'h8, r);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL irq_drain: got %h required %h", r, e); end
   endtask
   task automatic test_flush();
      logic [31:0] r, w;
      int n = 0;
      for (int i = 0; i < 5; i++) push_word($urandom);
      pl_data = 32'hDEAD_BEEF; pl_valid = 1'b1;
      s.awaddr = 4'h0; s.wdata = 32'h3; s.wstrb = 4'hF; s.awvalid = 1'b1; s.wvalid = 1'b1;
      while (!s.awready && n < 20) begin tick(); n++; end
      tick();
      pl_valid = 1'b0; s.awvalid = 1'b0; s.wvalid = 1'b0; s.bready = 1'b1;
      n = 0;
      while (!s.bvalid && n < 20) begin tick(); n++; end
      tick();
      s.bready = 1'b0;
      q.delete();
      axi_read(4'hC, r);
      n_checks++; if (r !== 32'h0001_0000) begin n_fail++; $display("FAIL flush_status: got %h required 00010000", r); end
      axi_read(4'h0, r);
      n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL flush_ctrl: got %h required 1", r); end
      w = $urandom;
      push_word(w);
      void'(q.pop_front());
      axi_read(4'h8, r);
      n_checks++; if (r !== w) begin n_fail++; $display("FAIL flush_repush: got %h required %h", r, w); end
   endtask
   task automatic test_random();
      logic [31:0] r, e, d;
      logic [3:0] strb;
      axi_write(4'h0, 32'h5, 4'hF);
      m_irq_en = 1'b1;
      m_thresh = 8'($urandom_range(1, DEPTH));
      axi_write(4'h4, 32'(m_thresh), 4'hF);
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: if (q.size() < DEPTH) push_word($urandom);
               else begin
                  pl_data = $urandom; pl_valid = 1'b1;
                  n_checks++; if (pl_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_full_ready: pl_ready=%b required 0", pl_ready); end
                  tick();
                  pl_valid = 1'b0;
                  m_ovf = 1'b1;
               end
            4, 5, 6: begin
               if (q.size() > 0) e = q.pop_front();
               else begin e = 32'h0; m_unf = 1'b1; end
               axi_read(4'h8, r);
               n_checks++; if (r !== e) begin n_fail++; $display("FAIL rnd_data: got %h required %h", r, e); end
            end
            7: begin
               axi_read(4'hC, r);
               n_checks++; if (r !== m_status()) begin n_fail++; $display("FAIL rnd_status: got %h required %h", r, m_status()); end
            end
            8: begin
               d = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, DEPTH + 2));
               strb = 4'($urandom);
               axi_write(4'h4, d, strb);
               if (strb[0]) m_thresh = d[7:0];
            end
            default: begin
               d = $urandom;
               strb = 4'($urandom);
               axi_write(4'hC, d, strb);
               if (strb[2] && d[18]) m_ovf = 1'b0;
               if (strb[2] && d[19]) m_unf = 1'b0;
            end
         endcase
         n_checks++; if (irq !== m_irq()) begin n_fail++; $display("FAIL rnd_irq: irq=%b required %b (count %0d thresh %0d)", irq, m_irq(), q.size(), m_thresh); end
      end
      axi_read(4'hC, r);
      n_checks++; if (r !== m_status()) begin n_fail++; $display("FAIL rnd_final_status: got %h required %h", r, m_status()); end
   endtask
   task automatic test_reset_mid();
      logic [31:0] r;
      int n = 0;
      axi_write(4'h0, 32'h1, 4'hF);
      push_word($urandom);
      push_word($urandom);
      s.araddr = 4'hC; s.arvalid = 1'b1;
      while (!s.arready && n < 20) begin tick(); n++; end
      rst_n = 1'b0;
      #1;
      n_checks++; if (s.arready !== 1'b0 || pl_ready !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_drop: arready=%b pl_ready=%b irq=%b required 0 0 0", s.arready, pl_ready, irq); end
      s.arvalid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_irq_en = 1'b0; m_thresh = 8'd0;
      axi_read(4'hC, r);
      n_checks++; if (r !== m_status()) begin n_fail++; $display("FAIL mid_reset_status: got %h required %h", r, m_status()); end
      axi_read(4'h0, r);
      n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL mid_reset_ctrl: got %h required 0", r); end
   endtask
   initial begin
      s.awaddr = '0; s.awprot = '0; s.awvalid = 1'b0; s.wdata = '0; s.wstrb = '0; s.wvalid = 1'b0;
      s.bready = 1'b0; s.araddr = '0; s.arprot = '0; s.arvalid = 1'b0; s.rready = 1'b0;
      test_reset();
      test_regs();
      test_fifo_basic();
      test_full();
      test_irq();
      test_flush();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1);
   end
endmodule
